// File: rtl/ana_pad_sequencer_if.sv
// Command channel into the pad sequencer: valid/ready handshake carrying an opcode and payload.
interface ana_pad_sequencer_if #(
  parameter int DW = 8
) ();
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          cmd_ready;

  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready);
endinterface

// File: rtl/ana_pad_sequencer.sv
// Plays a programmed pattern table onto the pad bus, holding each entry for dwell+1 cycles
// and capturing pad_in at the end of every dwell; optional looping, stop and status flags.
module ana_pad_sequencer #(
  parameter  int DEPTH = 4,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  ana_pad_sequencer_if.slave    cmd,
  input  logic [DW-1:0]         pad_in,
  output logic [DW-1:0]         pad_out,
  output logic [DW-1:0]         pad_oe,
  input  logic [AW-1:0]         cap_sel,
  output logic [DW-1:0]         cap_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [DW-1:0] oe_q, dwell_q, timer_q;
  logic [AW:0]   count_q;
  logic [AW-1:0] idx_q;
  logic          loop_q, done_q, ovf_q, err_q;
  logic [DW-1:0] pat_q [DEPTH];
  logic [DW-1:0] cap_q [DEPTH];

  logic accept, is_ctrl, start_req, start_ok, start_bad, stop_req, clr_req;
  logic dwell_end, last;

  assign accept    = cmd.cmd_valid && cmd.cmd_ready;
  assign is_ctrl   = accept && (cmd.cmd_op == 2'd3);
  assign start_req = is_ctrl && cmd.cmd_data[0] && (state_q != S_RUN);
  assign stop_req  = is_ctrl && !cmd.cmd_data[0] && (state_q == S_RUN);
  assign clr_req   = is_ctrl && cmd.cmd_data[2] && (state_q != S_RUN);
  // A start bundled with a clear would run an empty table, so treat it as a failed start.
  assign start_ok  = start_req && !clr_req && (count_q != '0);
  assign start_bad = start_req && !start_ok;
  // Stop beats a coincident dwell end: no capture, index left as is.
  assign dwell_end = (state_q == S_RUN) && (timer_q == '0) && !stop_req;
  assign last      = ({1'b0, idx_q} == (count_q - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_RUN;
      S_RUN: begin
        if (stop_req)                          state_d = S_IDLE;
        else if (dwell_end && last && !loop_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd.cmd_ready = (state_q != S_RUN) || (cmd.cmd_op == 2'd3);
    busy          = (state_q == S_RUN);
    pad_out       = (state_q == S_RUN) ? pat_q[idx_q] : '0;
  end

  assign pad_oe   = oe_q;
  assign cap_data = cap_q[cap_sel];
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      oe_q    <= '0;
      dwell_q <= '0;
      timer_q <= '0;
      count_q <= '0;
      idx_q   <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pat_q[i] <= '0;
        cap_q[i] <= '0;
      end
    end else begin
      if (accept && cmd.cmd_op == 2'd0) oe_q <= cmd.cmd_data;
      if (accept && cmd.cmd_op == 2'd2) dwell_q <= cmd.cmd_data;
      if (accept && cmd.cmd_op == 2'd1) begin
        if (count_q != DEPTH_C) begin
          pat_q[count_q[AW-1:0]] <= cmd.cmd_data;
          count_q                <= count_q + 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end
      if (clr_req) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end
      if (start_bad) err_q <= 1'b1;
      if (start_ok) begin
        idx_q   <= '0;
        timer_q <= dwell_q;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        loop_q  <= cmd.cmd_data[1];
      end
      if (dwell_end) begin
        cap_q[idx_q] <= pad_in;
        timer_q      <= dwell_q;
        idx_q        <= last ? '0 : idx_q + 1'b1;
        if (last && !loop_q) done_q <= 1'b1;
      end else if (state_q == S_RUN && !stop_req) begin
        timer_q <= timer_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ana_pad_sequencer.sv
// Directed stimulus with a cycle-stamped scoreboard; a monitor pops and compares each expectation.
module tb_ana_pad_sequencer;

  localparam int K_OUT = 0, K_OE = 1, K_BUSY = 2, K_DONE = 3, K_OVF = 4, K_ERR = 5, K_CAP = 6, K_RDY = 7;

  typedef struct {
    int         cyc;
    int         kind;
    int         sel;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pad_in = 8'h00;
  logic [7:0] pad_out, pad_oe, cap_data;
  logic [1:0] cap_sel = 2'd0;
  logic       busy, done, ovf, err;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  exp_t       q[$];

  ana_pad_sequencer_if #(.DW(8)) intf ();

  ana_pad_sequencer #(.DEPTH(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .cmd(intf.slave),
    .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe),
    .cap_sel(cap_sel), .cap_data(cap_data),
    .busy(busy), .done(done), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(int k);
    case (k)
      K_OUT:   return "pad_out";
      K_OE:    return "pad_oe";
      K_BUSY:  return "busy";
      K_DONE:  return "done";
      K_OVF:   return "ovf";
      K_ERR:   return "err";
      K_CAP:   return "cap_data";
      default: return "cmd_ready";
    endcase
  endfunction

  function automatic void push_exp(int c, int k, int s, logic [7:0] v);
    exp_t e;
    int   i;
    e.cyc = c; e.kind = k; e.sel = s; e.val = v;
    i = 0;
    while (i < q.size() && q[i].cyc <= c) i++;
    q.insert(i, e);
  endfunction

  // Monitor: compares every expectation due in the current cycle on the falling edge.
  initial begin
    exp_t       e;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          failures++;
          $display("FAIL %s sel=%0d not sampled at cycle %0d (now %0d)", kname(e.kind), e.sel, e.cyc, cyc);
        end else begin
          got = 8'h00;
          case (e.kind)
            K_OUT:  got = pad_out;
            K_OE:   got = pad_oe;
            K_BUSY: got = {7'd0, busy};
            K_DONE: got = {7'd0, done};
            K_OVF:  got = {7'd0, ovf};
            K_ERR:  got = {7'd0, err};
            K_CAP: begin
              cap_sel = e.sel[1:0];
              #1;
              got = cap_data;
            end
            default: got = {7'd0, intf.cmd_ready};
          endcase
          if (got !== e.val)  begin
            failures++;
            $display("FAIL %s sel=%0d cycle=%0d got=%h expected=%h", kname(e.kind), e.sel, cyc, got, e.val);
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] d, output int s);
    int n;
    n = 0;
    @(negedge clk);
    intf.cmd_valid = 1'b1;
    intf.cmd_op    = op;
    intf.cmd_data  = d;
    #1;
    while (!intf.cmd_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!intf.cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout op=%0d got=ready0 expected=ready1", op);
    end
    @(posedge clk);
    #1;
    s = cyc;
    intf.cmd_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int r, s, z, t;
    intf.cmd_valid = 1'b0;
    intf.cmd_op    = 2'd0;
    intf.cmd_data  = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    r = cyc;
    push_exp(r, K_OUT, 0, 8'h00);
    push_exp(r, K_OE, 0, 8'h00);
    push_exp(r, K_BUSY, 0, 8'h00);
    push_exp(r, K_DONE, 0, 8'h00);
    push_exp(r, K_OVF, 0, 8'h00);
    push_exp(r, K_ERR, 0, 8'h00);
    push_exp(r, K_RDY, 0, 8'h01);
    for (int i = 0; i < 4; i++) push_exp(r, K_CAP, i, 8'h00);

    // Two-entry run, dwell 2, with captures A5 / 5A
    send(2'd0, 8'hFF, t);
    send(2'd1, 8'h11, t);
    send(2'd1, 8'h22, t);
    send(2'd2, 8'h02, t);
    pad_in = 8'hA5;
    send(2'd3, 8'h01, s);
    push_exp(s, K_BUSY, 0, 8'h01);
    push_exp(s, K_DONE, 0, 8'h00);
    push_exp(s, K_OE, 0, 8'hFF);
    for (int i = 0; i < 3; i++) push_exp(s + i, K_OUT, 0, 8'h11);
    for (int i = 3; i < 6; i++) push_exp(s + i, K_OUT, 0, 8'h22);
    push_exp(s + 6, K_OUT, 0, 8'h00);
    push_exp(s + 6, K_DONE, 0, 8'h01);
    push_exp(s + 6, K_BUSY, 0, 8'h00);
    push_exp(s + 6, K_CAP, 0, 8'hA5);
    push_exp(s + 6, K_CAP, 1, 8'h5A);
    wait_cyc(s + 3);
    pad_in = 8'h5A;
    wait_cyc(s + 8);

    // Overflow: clear, five writes into four entries, replay with dwell 0
    send(2'd3, 8'h04, t);
    send(2'd2, 8'h00, t);
    send(2'd1, 8'h01, t);
    send(2'd1, 8'h02, t);
    send(2'd1, 8'h03, t);
    send(2'd1, 8'h04, t);
    push_exp(t, K_OVF, 0, 8'h00);
    send(2'd1, 8'h05, t);
    push_exp(t, K_OVF, 0, 8'h01);
    send(2'd3, 8'h01, s);
    for (int i = 0; i < 4; i++) push_exp(s + i, K_OUT, 0, 8'(i + 1));
    push_exp(s + 4, K_OUT, 0, 8'h00);
    push_exp(s + 4, K_DONE, 0, 8'h01);
    wait_cyc(s + 5);
    send(2'd3, 8'h04, t);
    push_exp(t, K_OVF, 0, 8'h00);

    // Start on an empty table is refused
    send(2'd3, 8'h01, t);
    push_exp(t, K_ERR, 0, 8'h01);
    push_exp(t, K_BUSY, 0, 8'h00);
    push_exp(t + 1, K_BUSY, 0, 8'h00);

    // Loop with dwell 0, stop landing on a dwell end
    send(2'd1, 8'h31, t);
    send(2'd1, 8'h32, t);
    send(2'd1, 8'h33, t);
    pad_in = 8'hC3;
    send(2'd3, 8'h03, s);
    push_exp(s, K_ERR, 0, 8'h00);
    push_exp(s, K_OUT, 0, 8'h31);
    push_exp(s + 1, K_OUT, 0, 8'h32);
    push_exp(s + 2, K_OUT, 0, 8'h33);
    push_exp(s + 3, K_OUT, 0, 8'h31);
    push_exp(s + 4, K_OUT, 0, 8'h32);
    wait_cyc(s + 4);
    @(negedge clk);
    pad_in = 8'h77;
    intf.cmd_valid = 1'b1;
    intf.cmd_op    = 2'd3;
    intf.cmd_data  = 8'h00;
    @(posedge clk);
    #1;
    z = cyc;
    intf.cmd_valid = 1'b0;
    push_exp(z, K_BUSY, 0, 8'h00);
    push_exp(z, K_OUT, 0, 8'h00);
    push_exp(z, K_DONE, 0, 8'h00);
    for (int i = 0; i < 3; i++) push_exp(z, K_CAP, i, 8'hC3);
    push_exp(z, K_CAP, 3, 8'h5A);

    // Non-CTRL command stalls during RUN, then goes through after stop
    send(2'd3, 8'h03, s);
    intf.cmd_valid = 1'b1;
    intf.cmd_op    = 2'd0;
    intf.cmd_data  = 8'h0F;
    for (int i = 0; i < 3; i++) push_exp(s + i, K_RDY, 0, 8'h00);
    push_exp(s + 2, K_BUSY, 0, 8'h01);
    push_exp(s + 2, K_OE, 0, 8'hFF);
    push_exp(s + 4, K_RDY, 0, 8'h01);
    push_exp(s + 4, K_BUSY, 0, 8'h00);
    push_exp(s + 5, K_OE, 0, 8'h0F);
    wait_cyc(s + 3);
    intf.cmd_op   = 2'd3;
    intf.cmd_data = 8'h00;
    wait_cyc(s + 4);
    intf.cmd_op   = 2'd0;
    intf.cmd_data = 8'h0F;
    wait_cyc(s + 5);
    intf.cmd_valid = 1'b0;
    wait_cyc(s + 6);

    // Reset mid-run, then reset beats a coincident WR_OE
    send(2'd3, 8'h03, s);
    push_exp(s, K_BUSY, 0, 8'h01);
    push_exp(s, K_OE, 0, 8'h0F);
    wait_cyc(s + 2);
    rst = 1'b1;
    intf.cmd_valid = 1'b1;
    intf.cmd_op    = 2'd0;
    intf.cmd_data  = 8'hAA;
    push_exp(s + 3, K_OUT, 0, 8'h00);
    push_exp(s + 3, K_OE, 0, 8'h00);
    push_exp(s + 3, K_BUSY, 0, 8'h00);
    push_exp(s + 3, K_RDY, 0, 8'h01);
    push_exp(s + 3, K_CAP, 0, 8'h00);
    push_exp(s + 3, K_CAP, 1, 8'h00);
    push_exp(s + 5, K_OE, 0, 8'h00);
    push_exp(s + 5, K_OUT, 0, 8'h00);
    wait_cyc(s + 4);
    rst = 1'b0;
    intf.cmd_valid = 1'b0;

    for (int n = 0; n < 100 && q.size() > 0; n++) @(negedge clk);
    #3;
    if (q.size() > 0) begin
      failures += q.size();
      $display("FAIL drain got=%0d_pending expected=0_pending", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
